tt_spine_ctrl: RTL and testbench

TT_SPINE_CTRL -- requirements
Module: tt_spine_ctrl

---
 rtl/tt_spine_ctrl_pkg.sv | 28 ++
 rtl/tt_spine_ctrl_if.sv | 24 ++
 rtl/tt_spine_ctrl_sync.sv | 29 ++
 rtl/tt_spine_ctrl.sv | 115 +++++++++++
 tb/tb_tt_spine_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/tt_spine_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tt_spine_ctrl_pkg
// Purpose  : shared state encoding and spine field offsets
// Revision : 1.0
// ---------------------------------------------------------------------------
package tt_spine_ctrl_pkg;

   localparam int c_sel_w = 10;

   // Input-word offsets: {gh, usr, sel, ena, gl}
   localparam int c_iw_gl  = 0;
   localparam int c_iw_ena = 1;
   localparam int c_iw_sel = 2;
   localparam int c_iw_usr = c_iw_sel + c_sel_w;

   // Output-word offsets: {gh, uio_oe, uio_out, uo_out, gl}
   localparam int c_ow_gl  = 0;
   localparam int c_ow_usr = 1;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/tt_spine_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tt_spine_ctrl_if
// Purpose  : packed spine words between the controller and the row muxes
// Revision : 1.0
// ---------------------------------------------------------------------------
interface tt_spine_ctrl_if
   import tt_spine_ctrl_pkg::*;
#(
   parameter int N_IO = 8,
   parameter int N_O  = 8,
   parameter int N_I  = 10
);
   localparam int S_OW = N_O + 2*N_IO + 2;
   localparam int S_IW = N_I + N_IO + c_sel_w + 3;

   logic [S_IW-1:0] spine_iw;
   logic [S_OW-1:0] spine_ow;

   modport master (output spine_iw, input  spine_ow);
   modport slave  (input  spine_iw, output spine_ow);

endinterface
`default_nettype wire

// File: rtl/tt_spine_ctrl_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tt_ctrl_sync
// Purpose  : two-flop synchronizer for one pad-level control input
// Revision : 1.0
// ---------------------------------------------------------------------------
module tt_ctrl_sync (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic d,
   output logic      q
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/tt_spine_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tt_spine_ctrl
// Purpose  : design-select counter, settle FSM and pad/spine field mapping
// Revision : 1.0
// ---------------------------------------------------------------------------
module tt_spine_ctrl
   import tt_spine_ctrl_pkg::*;
#(
   parameter int N_IO   = 8,
   parameter int N_O    = 8,
   parameter int N_I    = 10,
   parameter int SETTLE = 2
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   input  wire logic                 ctrl_sel_rst_n,
   input  wire logic                 ctrl_sel_inc,
   input  wire logic                 ctrl_ena,
   input  wire logic [N_I-1:0]       pad_ui_in,
   input  wire logic [N_IO-1:0]      pad_uio_in,
   output logic      [N_O-1:0]       pad_uo_out,
   output logic      [N_IO-1:0]      pad_uio_out,
   output logic      [N_IO-1:0]      pad_uio_oe_n,
   tt_spine_ctrl_if.master           spine,
   output logic      [c_sel_w-1:0]   sel_cur
);
   localparam int S_OW = N_O + 2*N_IO + 2;

   logic               w_srst_n_s;
   logic               w_inc_s;
   logic               w_ena_s;
   logic               r_inc_d;
   logic               w_inc_edge;
   logic [c_sel_w-1:0] r_sel;
   logic               r_ena;
   state_t             r_state;
   state_t             w_state;
   logic [3:0]         r_cnt;
   logic [3:0]         w_cnt;
   logic               w_unused;

   tt_ctrl_sync u_sync_srst (.clk(clk), .rst_n(rst_n), .d(ctrl_sel_rst_n), .q(w_srst_n_s));
   tt_ctrl_sync u_sync_inc  (.clk(clk), .rst_n(rst_n), .d(ctrl_sel_inc),   .q(w_inc_s));
   tt_ctrl_sync u_sync_ena  (.clk(clk), .rst_n(rst_n), .d(ctrl_ena),       .q(w_ena_s));

   assign w_inc_edge = w_inc_s & ~r_inc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inc_d <= 1'b0;
         r_sel   <= '0;
         r_state <= ST_RESET;
         r_cnt   <= 4'd0;
         r_ena   <= 1'b0;
      end else begin
         r_inc_d <= w_inc_s;
         // Selection reset wins over a coincident increment edge
         if (!w_srst_n_s)
            r_sel <= '0;
         else if (w_inc_edge)
            r_sel <= r_sel + 1'b1;
         r_state <= w_state;
         r_cnt   <= w_cnt;
         // Keyed on next state so ena drops on the very edge that moves sel
         r_ena   <= w_ena_s & (w_state == ST_ACTIVE);
      end
   end

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      if (!w_srst_n_s) begin
         w_state = ST_RESET;
         w_cnt   = 4'd0;
      end else begin
         case (r_state)
            ST_RESET: begin
               w_state = ST_SETTLE;
               w_cnt   = 4'(SETTLE);
            end
            ST_SETTLE: begin
               if (w_inc_edge)
                  w_cnt = 4'(SETTLE);
               else if (r_cnt == 4'd0)
                  w_state = ST_ACTIVE;
               else
                  w_cnt = r_cnt - 4'd1;
            end
            ST_ACTIVE: begin
               if (w_inc_edge) begin
                  w_state = ST_SETTLE;
                  w_cnt   = 4'(SETTLE);
               end
            end
            default: begin
               w_state = ST_RESET;
               w_cnt   = 4'd0;
            end
         endcase
      end
   end

   assign spine.spine_iw = {1'b0, pad_uio_in, pad_ui_in, r_sel, r_ena, 1'b0};
   assign sel_cur        = r_sel;

   assign pad_uo_out   =  spine.spine_ow[c_ow_usr +: N_O];
   assign pad_uio_out  =  spine.spine_ow[c_ow_usr + N_O +: N_IO];
   assign pad_uio_oe_n = ~spine.spine_ow[c_ow_usr + N_O + N_IO +: N_IO];

   // Guard bits of the returning word carry no information
   assign w_unused = spine.spine_ow[S_OW-1] ^ spine.spine_ow[c_ow_gl];

endmodule
`default_nettype wire

// File: tb/tb_tt_spine_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_tt_spine_ctrl
// Purpose  : directed self-checking bench for tt_spine_ctrl
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_tt_spine_ctrl;
   localparam int N_IO   = 8;
   localparam int N_O    = 8;
   localparam int N_I    = 10;
   localparam int SETTLE = 2;
   localparam int S_IW   = N_I + N_IO + 13;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            ctrl_sel_rst_n = 1'b0;
   logic            ctrl_sel_inc = 1'b0;
   logic            ctrl_ena = 1'b0;
   logic [N_I-1:0]  pad_ui_in = '0;
   logic [N_IO-1:0] pad_uio_in = '0;
   logic [N_O-1:0]  pad_uo_out;
   logic [N_IO-1:0] pad_uio_out;
   logic [N_IO-1:0] pad_uio_oe_n;
   logic [9:0]      sel_cur;

   int n_pass = 0;
   int n_chk  = 0;
   int exp_sel = 0;

   tt_spine_ctrl_if #(.N_IO(N_IO), .N_O(N_O), .N_I(N_I)) u_if ();

   tt_spine_ctrl #(.N_IO(N_IO), .N_O(N_O), .N_I(N_I), .SETTLE(SETTLE)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ctrl_sel_rst_n (ctrl_sel_rst_n),
      .ctrl_sel_inc   (ctrl_sel_inc),
      .ctrl_ena       (ctrl_ena),
      .pad_ui_in      (pad_ui_in),
      .pad_uio_in     (pad_uio_in),
      .pad_uo_out     (pad_uo_out),
      .pad_uio_out    (pad_uio_out),
      .pad_uio_oe_n   (pad_uio_oe_n),
      .spine          (u_if),
      .sel_cur        (sel_cur)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   function automatic logic spine_ena();
      return u_if.spine_iw[1];
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One increment pulse, measuring pad-to-sel latency and sel-to-ena latency
   task automatic inc_measure(input string tag);
      logic [9:0] prev;
      int lat;
      int k;
      prev = sel_cur;
      ctrl_sel_inc = 1'b1;
      lat = 0;
      while (sel_cur == prev && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      exp_sel = (exp_sel + 1) % 1024;
      check({tag, "_sel"}, 32'(sel_cur), 32'(exp_sel));
      check({tag, "_lat"}, 32'(lat), 32'd3);
      check({tag, "_ena_low"}, 32'(spine_ena()), 32'd0);
      k = 0;
      while (spine_ena() == 1'b0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_settle"}, 32'(k), 32'(SETTLE + 1));
      ctrl_sel_inc = 1'b0;
      wait_cycles(4);
   endtask

   initial begin
      // Reset with selection reset held
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(5);
      check("rst_sel", 32'(sel_cur), 32'd0);
      check("rst_ena", 32'(spine_ena()), 32'd0);
      check("rst_gl",  32'(u_if.spine_iw[0]), 32'd0);
      check("rst_gh",  32'(u_if.spine_iw[S_IW-1]), 32'd0);

      // Combinational field mapping; guard bits driven 1 to show they are ignored
      u_if.spine_ow = {1'b1, 8'hF0, 8'h3C, 8'hA5, 1'b1};
      pad_ui_in  = 10'h155;
      pad_uio_in = 8'h5A;
      #1;
      check("map_oe_n",   32'(pad_uio_oe_n), 32'h0F);
      check("map_uo",     32'(pad_uo_out), 32'hA5);
      check("map_uio",    32'(pad_uio_out), 32'h3C);
      check("map_ui_in",  32'(u_if.spine_iw[12 +: 10]), 32'h155);
      check("map_uio_in", 32'(u_if.spine_iw[22 +: 8]), 32'h5A);
      u_if.spine_ow = {1'b0, 8'h0F, 8'hC3, 8'h5A, 1'b0};
      #1;
      check("map2_oe_n", 32'(pad_uio_oe_n), 32'hF0);
      check("map2_uo",   32'(pad_uo_out), 32'h5A);

      // Release selection reset, enable design 0
      @(negedge clk);
      ctrl_sel_rst_n = 1'b1;
      ctrl_ena = 1'b1;
      wait_cycles(10);
      check("act_ena", 32'(spine_ena()), 32'd1);
      check("act_sel", 32'(sel_cur), 32'd0);

      for (int i = 0; i < 5; i++) inc_measure($sformatf("inc%0d", i));
      check("five_sel", 32'(sel_cur), 32'd5);

      // Fast pulses up to 1023
      for (int i = 0; i < 1018; i++) begin
         ctrl_sel_inc = 1'b1;
         wait_cycles(3);
         ctrl_sel_inc = 1'b0;
         wait_cycles(3);
      end
      exp_sel = 1023;
      wait_cycles(8);
      check("pre_wrap_sel", 32'(sel_cur), 32'd1023);
      check("pre_wrap_ena", 32'(spine_ena()), 32'd1);
      inc_measure("wrap");

      // Increment edge coincident with selection reset: reset wins
      ctrl_sel_inc   = 1'b1;
      ctrl_sel_rst_n = 1'b0;
      wait_cycles(10);
      check("coinc_sel", 32'(sel_cur), 32'd0);
      check("coinc_ena", 32'(spine_ena()), 32'd0);
      ctrl_sel_inc = 1'b0;
      wait_cycles(4);
      ctrl_sel_rst_n = 1'b1;
      exp_sel = 0;
      wait_cycles(10);
      inc_measure("post");

      // Asynchronous reset while active and enabled
      check("pre_rst_ena", 32'(spine_ena()), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_ena", 32'(spine_ena()), 32'd0);
      check("async_sel", 32'(sel_cur), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("restart_ena", 32'(spine_ena()), 32'd0);
      wait_cycles(10);
      check("restart_ena2", 32'(spine_ena()), 32'd1);
      check("restart_sel",  32'(sel_cur), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
